// File: rtl/riscv_pkg.sv
// RV32I encoding constants and instruction classes shared by the encoder and decoder.
package riscv_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_SW      = 3'b010;

  // True when v, read as two's complement, is representable in 'bits' signed bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I field packer: builds the canonical word and flags illegal descriptors.
module instr_field_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic is_shift;
  logic alt_ok;

  always_comb begin
    word     = '0;
    illegal  = 1'b0;
    is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    alt_ok   = 1'b0;
    case (instr_class_t'(cls))
      CLS_R: begin
        word   = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OP_R};
        alt_ok = (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
      end
      CLS_I_ALU: begin
        alt_ok = (funct3 == F3_SRL_SRA);
        if (is_shift) begin
          word    = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OP_IMM};
          illegal = (imm[31:5] != '0);
        end else begin
          word    = {imm[11:0], rs1, funct3, rd, OP_IMM};
          illegal = !fits_signed(imm, 12);
        end
      end
      CLS_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        illegal = !fits_signed(imm, 12) || (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      CLS_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        illegal = !fits_signed(imm, 12) || (funct3 > F3_SW);
      end
      CLS_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        illegal = !fits_signed(imm, 13) || imm[0] || (funct3[2:1] == 2'b01);
      end
      CLS_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal = !fits_signed(imm, 21) || imm[0];
      end
      CLS_JALR: begin
        word    = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        illegal = !fits_signed(imm, 12);
      end
      CLS_LUI: begin
        word    = {imm[31:12], rd, OP_LUI};
        illegal = (imm[11:0] != '0);
      end
      CLS_AUIPC: begin
        word    = {imm[31:12], rd, OP_AUIPC};
        illegal = (imm[11:0] != '0);
      end
      default: illegal = 1'b1;
    endcase
    if (alt && !alt_ok) illegal = 1'b1;
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: descriptor handshake, encode stage, write-holding stage and
// sequential instruction-memory writes with fill tracking and a sticky error flag.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   err_index
);

  localparam logic [ADDR_W:0]   CAP   = (ADDR_W + 1)'(1) << ADDR_W;
  localparam logic [ADDR_W+1:0] CAP_X = (ADDR_W + 2)'(1) << ADDR_W;

  logic [31:0]       pk_word;
  logic              pk_illegal;
  logic              e_valid;
  logic              e_illegal;
  logic [31:0]       e_word;
  logic              w_valid;
  logic [ADDR_W+1:0] pending;
  logic              full_pending;
  logic              advance;
  logic              accept;
  logic              w_done;
  logic [ADDR_W:0]   count_next;

  instr_field_pack u_pack (
    .cls     (in_class),
    .funct3  (in_funct3),
    .alt     (in_alt),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  // Written words plus legal words still in E or W; illegal ones never consume capacity.
  assign pending      = {1'b0, count} + (ADDR_W + 2)'(e_valid & ~e_illegal) + (ADDR_W + 2)'(w_valid);
  assign full_pending = (pending >= CAP_X);
  assign advance      = !w_valid || imem_ready;
  assign in_ready     = rst_n && !full_pending && advance && !start;
  assign accept       = in_valid && in_ready;
  assign w_done       = w_valid && imem_ready;
  assign count_next   = count + (ADDR_W + 1)'(1);
  assign full         = (count == CAP);
  assign imem_we      = w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid    <= 1'b0;
      e_illegal  <= 1'b0;
      e_word     <= '0;
      w_valid    <= 1'b0;
      imem_wdata <= '0;
      imem_addr  <= ADDR_W'(BASE_ADDR);
      count      <= '0;
      err        <= 1'b0;
      err_index  <= '0;
    end else if (start) begin
      e_valid    <= 1'b0;
      e_illegal  <= 1'b0;
      e_word     <= '0;
      w_valid    <= 1'b0;
      imem_wdata <= '0;
      imem_addr  <= ADDR_W'(BASE_ADDR);
      count      <= '0;
      err        <= 1'b0;
      err_index  <= '0;
    end else begin
      if (w_done) begin
        count <= count_next;
        // The last slot keeps its address so the pointer never wraps back to the start.
        if (count_next != CAP) imem_addr <= imem_addr + ADDR_W'(1);
      end
      // E and W move together; an illegal descriptor in E simply leaves W empty.
      if (advance) begin
        w_valid <= e_valid & ~e_illegal;
        if (e_valid && !e_illegal) imem_wdata <= e_word;
        e_valid   <= accept;
        e_illegal <= pk_illegal;
        e_word    <= pk_word;
      end
      if (accept && pk_illegal && !err) begin
        err       <= 1'b1;
        err_index <= count;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the core's instruction decode path.
- Accepts field-level instruction descriptors (class, funct3, alt bit, rd/rs1/rs2, immediate) over a valid/ready handshake.
- Assembles the canonical 32-bit instruction word and range-checks all fields.
- Writes each legal word to consecutive instruction-memory addresses.
- Sits between the bench/boot loader and the instruction memory, so programs are built from fields rather than hand-coded hex.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; capacity 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after reset or start.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous restart: clear counter, pipeline and error.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid & in_ready.
- in_class  in  4  instr_class_t: R, I_ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- in_funct3  in  3  funct3 field.
- in_alt  in  1  funct7[5] (SUB/SRA/SRAI select).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte-offset or immediate value, unshifted.
- imem_we  out  1  write request (valid).
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/start.
- full  out  1  count == 2**ADDR_W.
- err  out  1  sticky illegal-descriptor flag.
- err_index  out  ADDR_W+1  value of count when the first error occurred.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; imem_addr = BASE_ADDR; pipeline empty.
- Pipeline, two stages:
  - Stage E: registered encode and check on the accept edge.
  - Stage W: output holding register driving imem_*.
- Latency: accepted at edge N gives imem_we high from edge N+1. Full throughput is one word per cycle while imem_ready stays high.
- in_ready = !full_pending & (!W_valid | imem_ready) & !start. full_pending counts in-flight words.
- imem_we stays high with stable addr/wdata until imem_ready is seen. On handshake: count+1, imem_addr+1.
- Encoding is the standard RV32I format per class; unused fields are forced to 0.
  - R: opcode 0110011, funct7 = {1'b0, alt, 5'b0}.
  - I_ALU: opcode 0010011. Shifts (funct3 001/101) use imm[4:0] with funct7 = {0, alt, 00000}.
  - LOAD 0000011; STORE 0100011; BRANCH 1100011; JAL 1101111; JALR 1100111 (funct3 forced 000).
  - LUI 0110111; AUIPC 0010111, both taking imm[31:12].
- Legality checks; any failure makes the descriptor illegal:
  - I/LOAD/STORE/JALR: imm must fit 12-bit signed.
  - BRANCH: imm must fit 13-bit signed, with imm[0]=0.
  - JAL: imm must fit 21-bit signed, with imm[0]=0.
  - LUI/AUIPC: imm[11:0] must be 0.
  - Shifts: imm[11:5] must be 0 (alt is carried separately).
  - alt=1 is allowed only for R with funct3 000/101, and for I_ALU with funct3 101.
  - LOAD funct3 must be in {000,001,010,100,101}.
  - STORE funct3 must be ≤ 010.
  - BRANCH funct3 must not be 010 or 011.
  - in_class must not be an undefined encoding.
- An illegal descriptor is consumed but not written: count and address are unchanged. err is set. err_index latches only on the first error; err stays set until start or reset.
- Full: once count plus in-flight reaches 2**ADDR_W, in_ready=0. Address never wraps.
- start has priority over everything:
  - drops any pending W word, including one mid-handshake;
  - count=0, addr=BASE_ADDR, err=0;
  - in_ready=0 during the start cycle.
- A descriptor presented in the same cycle as start is not accepted.

Decomposition:
- riscv_pkg holds:
  - instr_class_t enum;
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - funct3 constants shared with the decoder.
- One combinational sub-module, instr_field_pack: class/fields/imm in, {word, illegal} out. Stage registers, counter and handshake stay in the top level.

Test Plan:
- Reset, then in turn: addi x1,x0,5; add x3,x1,x2; sub x3,x1,x2 (alt=1), with imem_ready=1. Expect words 0x00500093, 0x002081B3, 0x402081B3 at addresses 0,1,2; count=3; one write per cycle.
- sw x2,8(x1); beq x1,x2,-4; jal x1,8; lui x5,0x12345000. Expect 0x0020A423, 0xFE208EE3, 0x008000EF, 0x123452B7.
- Hold imem_ready=0 for 3 cycles mid-stream. Expect imem_addr/wdata stable, in_ready low once W is full, and no word lost or duplicated.
- Send addi with imm=2048, then beq with imm=3, then a valid addi. Expect no writes for the first two; err=1 with err_index=0; the valid word lands at address 0.
- ADDR_W=2: send 5 legal descriptors. Expect 4 writes, full=1, in_ready=0 from then on, and imem_addr never returns to 0.
- Assert start while a word is stalled in W (imem_ready=0), then send addi. Expect the stalled word dropped, err cleared, and the new word written at BASE_ADDR with count=1.
